uart_tx_frame: RTL and testbench

Parametrised asynchronous serial transmitter for the board's UART links (Bluetooth module, servo controller, debug port), the next generation of our fixed 8N2 transmitter. It serialises one character per `TxD_start` strobe with compile-time data width, parity mode and stop-bit count, using a fractional baud accumulator. It sits between the TX FIFO read side and the `uart_tx` pin. It adds a synchronous reset and an optional line-break generator.

---
 rtl/uart_tx_frame_if.sv | 21 ++
 rtl/uart_tx_frame.sv | 142 ++++++++++++++
 tb/tb_uart_tx_frame.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if: character-request / serial-line bundle for uart_tx_frame.
// master drives the request side; slave is the transmitter.
interface uart_tx_frame_if #(
  parameter int DataBits = 8
) ();
  logic                TxD_start;
  logic [DataBits-1:0] TxD_data;
  logic                TxD_break;
  logic                TxD;
  logic                TxD_busy;

  modport master (
    output TxD_start, TxD_data, TxD_break,
    input  TxD, TxD_busy
  );

  modport slave (
    input  TxD_start, TxD_data, TxD_break,
    output TxD, TxD_busy
  );
endinterface

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter, fractional baud accumulator.
// Optional line-break generator enabled by defining UART_TX_BREAK_EN.
module uart_tx_frame #(
  parameter int ClkFrequency = 25000000,
  parameter int Baud         = 115200,
  parameter int AccWidth     = 16,
  parameter int DataBits     = 8,
  parameter int Parity       = 0,
  parameter int StopBits     = 1
) (
  input logic           clk,
  input logic           rst,
  uart_tx_frame_if.slave tx
);

  if (DataBits < 5 || DataBits > 9) begin : g_bad_db
    $error("uart_tx_frame: DataBits must be 5..9");
  end
  if (StopBits < 1 || StopBits > 2) begin : g_bad_sb
    $error("uart_tx_frame: StopBits must be 1 or 2");
  end
  if (Parity < 0 || Parity > 2) begin : g_bad_par
    $error("uart_tx_frame: Parity must be 0, 1 or 2");
  end

  localparam longint INC_L =
    ((longint'(Baud) << (AccWidth - 4)) +
     (longint'(ClkFrequency) >> 5)) /
    (longint'(ClkFrequency) >> 4);
  localparam logic [AccWidth:0] INC = INC_L[AccWidth:0];
  localparam logic [3:0] LAST_D = 4'(DataBits - 1);
  localparam logic [3:0] LAST_S = 4'(StopBits - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PAR, STOP
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [AccWidth:0]   r_acc;
  logic [DataBits-1:0] r_shift;
  logic                r_par;
  logic [3:0]          r_cnt;
  logic                r_txd;
  logic                r_busy;

  logic w_tick;
  logic w_brk_req;
  logic w_accept;
  logic w_line;
  logic w_txd_nxt;
  logic w_busy_nxt;

  assign w_tick = r_acc[AccWidth];

`ifdef UART_TX_BREAK_EN
  assign w_brk_req = tx.TxD_break & (r_state == IDLE);
`else
  assign w_brk_req = 1'b0;
`endif

  // busy covers the cycle after the last stop tick, so accept waits for it
  assign w_accept = tx.TxD_start & ~r_busy &
                    (r_state == IDLE) & ~w_brk_req;

  assign tx.TxD      = r_txd;
  assign tx.TxD_busy = r_busy;

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // next-state decode, one transition per baud tick
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (w_accept) w_next = START;
      START: if (w_tick) w_next = DATA;
      DATA:
        if (w_tick && r_cnt == LAST_D)
          w_next = (Parity != 0) ? PAR : STOP;
      PAR:   if (w_tick) w_next = STOP;
      STOP:
        if (w_tick && r_cnt == LAST_S)
          w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // line level and busy for the current state, registered below
  always_comb begin
    w_line = 1'b1;
    case (r_state)
      START:   w_line = 1'b0;
      DATA:    w_line = r_shift[0];
      PAR:     w_line = r_par;
      default: w_line = 1'b1;
    endcase
    w_txd_nxt  = w_brk_req ? 1'b0 : w_line;
    w_busy_nxt = (r_state != IDLE) | w_brk_req;
  end

  // baud accumulator, shifter, bit counter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_cnt   <= '0;
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_txd  <= w_txd_nxt;
      r_busy <= w_busy_nxt;
      // accept cycle is the first baud step: start bit spans a full period
      if (w_accept)
        r_acc <= INC;
      else if (r_state == IDLE)
        r_acc <= '0;
      else
        r_acc <= {1'b0, r_acc[AccWidth-1:0]} + INC;
      if (w_accept) begin
        r_shift <= tx.TxD_data;
        r_par   <= (Parity == 2) ? ~^tx.TxD_data
                                 : ^tx.TxD_data;
        r_cnt   <= '0;
      end else if (w_tick) begin
        case (r_state)
          DATA: begin
            r_shift <= r_shift >> 1;
            r_cnt   <= (r_cnt == LAST_D) ? 4'd0 : r_cnt + 4'd1;
          end
          STOP:    r_cnt <= r_cnt + 4'd1;
          default: r_cnt <= r_cnt;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: randomized frames against a bit-list line model.
// Three builds: 8N1, 7E2, 7O2; break test when UART_TX_BREAK_EN is set.
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] start_v = '0;
  logic [8:0] dv = '0;
  logic       brk = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;
  bit exp_q[$];

  int db_c[3] = '{8, 7, 7};
  int p_c[3]  = '{0, 1, 2};
  int sb_c[3] = '{1, 2, 2};

  always #5 clk = ~clk;

  uart_tx_frame_if #(.DataBits(8)) if0 ();
  uart_tx_frame_if #(.DataBits(7)) if1 ();
  uart_tx_frame_if #(.DataBits(7)) if2 ();

  assign if0.TxD_start = start_v[0];
  assign if0.TxD_data  = dv[7:0];
  assign if0.TxD_break = brk;
  assign if1.TxD_start = start_v[1];
  assign if1.TxD_data  = dv[6:0];
  assign if1.TxD_break = 1'b0;
  assign if2.TxD_start = start_v[2];
  assign if2.TxD_data  = dv[6:0];
  assign if2.TxD_break = 1'b0;

  uart_tx_frame #(
    .ClkFrequency(1843200), .Baud(115200), .AccWidth(16),
    .DataBits(8), .Parity(0), .StopBits(1)
  ) u0 (.clk(clk), .rst(rst), .tx(if0));

  uart_tx_frame #(
    .ClkFrequency(1843200), .Baud(115200), .AccWidth(16),
    .DataBits(7), .Parity(1), .StopBits(2)
  ) u1 (.clk(clk), .rst(rst), .tx(if1));

  uart_tx_frame #(
    .ClkFrequency(1843200), .Baud(115200), .AccWidth(16),
    .DataBits(7), .Parity(2), .StopBits(2)
  ) u2 (.clk(clk), .rst(rst), .tx(if2));

  function automatic logic txd_of(input int s);
    case (s)
      0:       return if0.TxD;
      1:       return if1.TxD;
      default: return if2.TxD;
    endcase
  endfunction

  function automatic logic busy_of(input int s);
    case (s)
      0:       return if0.TxD_busy;
      1:       return if1.TxD_busy;
      default: return if2.TxD_busy;
    endcase
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // line model: list of bit levels for one frame
  task automatic build(input int s, input logic [8:0] d);
    int ones;
    ones = 0;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < db_c[s]; i++) begin
      exp_q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (p_c[s] == 1) exp_q.push_back(bit'(ones % 2));
    if (p_c[s] == 2) exp_q.push_back(bit'(1 - ones % 2));
    for (int i = 0; i < sb_c[s]; i++) exp_q.push_back(1'b1);
  endtask

  task automatic idle(input int s, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("u%0d_idle_txd", s), 32'(txd_of(s)), 32'd1);
      chk($sformatf("u%0d_idle_busy", s), 32'(busy_of(s)), 32'd0);
    end
  endtask

  // caller is at a negedge; ign_t pulses a second start, rst_t aborts
  task automatic frame(input int s, input logic [8:0] d,
                       input int ign_t, input int rst_t);
    int  len;
    logic et, eb;
    build(s, d);
    len = exp_q.size() * 16;
    dv = d;
    start_v[s] = 1'b1;
    @(negedge clk);
    start_v[s] = 1'b0;
    chk($sformatf("u%0d_acc_txd", s), 32'(txd_of(s)), 32'd1);
    chk($sformatf("u%0d_acc_busy", s), 32'(busy_of(s)), 32'd0);
    for (int t = 1; t <= len + 1; t++) begin
      @(negedge clk);
      if (t == ign_t) begin
        dv = 9'h0AA;
        start_v[s] = 1'b1;
      end else begin
        start_v[s] = 1'b0;
      end
      if (t == rst_t) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk($sformatf("u%0d_rst_txd", s), 32'(txd_of(s)), 32'd1);
        chk($sformatf("u%0d_rst_busy", s), 32'(busy_of(s)), 32'd0);
        return;
      end
      et = (t <= len) ? exp_q[(t - 1) / 16] : 1'b1;
      eb = (t <= len);
      chk($sformatf("u%0d_d%0h_t%0d_txd", s, d, t),
          32'(txd_of(s)), 32'(et));
      chk($sformatf("u%0d_d%0h_t%0d_busy", s, d, t),
          32'(busy_of(s)), 32'(eb));
    end
    start_v[s] = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("u%0d_reset_txd", s), 32'(txd_of(s)), 32'd1);
      chk($sformatf("u%0d_reset_busy", s), 32'(busy_of(s)), 32'd0);
    end
    rst = 1'b0;
    idle(0, 2);

    frame(0, 9'h055, 0, 0);
    idle(0, 5);
    frame(1, 9'h041, 0, 0);
    idle(1, 5);
    frame(2, 9'h041, 0, 0);
    idle(2, 3);
    frame(2, 9'h000, 0, 0);
    idle(2, 3);

    frame(0, 9'h00F, 40, 0);
    idle(0, 40);
    frame(0, 9'h081, 0, 0);
    frame(0, 9'h03C, 0, 0);
    idle(0, 5);

    frame(0, 9'h0A5, 0, 72);
    idle(0, 10);
    frame(0, 9'h0A5, 0, 0);
    idle(0, 5);

    for (int r = 0; r < 12; r++) begin
      int s;
      s = $urandom_range(0, 2);
      frame(s, 9'($urandom), 0, 0);
      idle(s, $urandom_range(0, 4));
    end

`ifdef UART_TX_BREAK_EN
    brk = 1'b1;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      chk("brk_txd", 32'(if0.TxD), 32'd0);
      chk("brk_busy", 32'(if0.TxD_busy), 32'd1);
      start_v[0] = ($urandom_range(0, 7) == 0);
      dv = 9'($urandom);
    end
    start_v[0] = 1'b0;
    brk = 1'b0;
    @(negedge clk);
    chk("brk_rel_txd", 32'(if0.TxD), 32'd1);
    chk("brk_rel_busy", 32'(if0.TxD_busy), 32'd0);
    idle(0, 3);
    frame(0, 9'h055, 0, 0);
    idle(0, 3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
